mem_resp: RTL and testbench

Single-port memory responder for the `mem_req`/`mem_write`/`mem_addr`/`mem_wdata` → `mem_rdata_vld`/`mem_rdata` bus driven by the compute initiators, such as the matmul engine. It is the target end of that bus.

- Holds a register-array word store and returns read data in order after a fixed, parameterized latency.
- Provides a lower-priority host port so a testbench or CPU can preload operands and dump results.
- Used as the behavioural/FPGA memory in front of the matmul block.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_resp_if.sv | 42 ++++
 rtl/mem_resp_dly.sv | 35 +++
 rtl/mem_resp.sv | 98 +++++++++
 tb/tb_mem_resp.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings and default widths for the mem_req/mem_rdata bus used by
// the compute initiators and the memory responder.
package mem_bus_pkg;

  localparam int unsigned MEM_AW     = 16;
  localparam int unsigned MEM_DW     = 32;
  localparam int unsigned RD_LAT_MAX = 8;

  typedef enum logic {
    MEM_CMD_RD = 1'b0,
    MEM_CMD_WR = 1'b1
  } mem_cmd_e;

  typedef enum logic {
    ARB_IDLE        = 1'b0,
    ARB_HOST_RD_RET = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_resp_if.sv
// Initiator bus plus host preload/dump port of the memory responder.
interface mem_resp_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
);

  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld;
  logic [DW-1:0] mem_rdata;

  logic          host_req;
  logic          host_write;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvld;
  logic [DW-1:0] host_rdata;

  logic          addr_err;

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  host_req, host_write, host_addr, host_wdata,
    output mem_rdata_vld, mem_rdata,
    output host_gnt, host_rvld, host_rdata,
    output addr_err
  );

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    output host_req, host_write, host_addr, host_wdata,
    input  mem_rdata_vld, mem_rdata,
    input  host_gnt, host_rvld, host_rdata,
    input  addr_err
  );

endinterface

// File: rtl/mem_resp_dly.sv
// LAT-deep valid+data shift pipeline with async clear; data is forced to zero
// in any stage that does not hold a valid entry.
module mem_resp_dly #(
  parameter int unsigned LAT = 2,
  parameter int unsigned DW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic [LAT-1:0]         r_vld;
  logic [LAT-1:0][DW-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_data[0] <= i_vld ? i_data : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_data = r_data[LAT-1];

endmodule

// File: rtl/mem_resp.sv
// Single-port word store answering the initiator bus with fixed read latency,
// plus a lower-priority host port that only gets idle bus cycles.
module mem_resp #(
  parameter int unsigned MEM_AW = mem_bus_pkg::MEM_AW,
  parameter int unsigned MEM_DW = mem_bus_pkg::MEM_DW,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_resp_if.slave bus
);

  import mem_bus_pkg::MEM_CMD_WR;
  import mem_bus_pkg::arb_state_e;
  import mem_bus_pkg::ARB_IDLE;
  import mem_bus_pkg::ARB_HOST_RD_RET;

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [MEM_DW-1:0] r_mem [DEPTH];
  arb_state_e        r_state;
  logic [MEM_DW-1:0] r_host_rdata;
  logic              r_addr_err;

  logic              w_bus_wr;
  logic              w_bus_rd;
  logic              w_host_gnt;
  logic              w_host_wr;
  logic              w_host_rd;
  logic              w_access;
  logic [MEM_AW-1:0] w_addr;
  logic [MEM_DW-1:0] w_wdata;
  logic              w_in_range;
  logic [IW-1:0]     w_idx;
  logic [MEM_DW-1:0] w_rd_word;
  logic              w_dly_vld;
  logic [MEM_DW-1:0] w_dly_data;

  // Bus wins every cycle it requests; the host only uses the port otherwise.
  always_comb begin
    w_bus_wr   = bus.mem_req & (bus.mem_write == MEM_CMD_WR);
    w_bus_rd   = bus.mem_req & ~(bus.mem_write == MEM_CMD_WR);
    w_host_gnt = bus.host_req & ~bus.mem_req;
    w_host_wr  = w_host_gnt & (bus.host_write == MEM_CMD_WR);
    w_host_rd  = w_host_gnt & ~(bus.host_write == MEM_CMD_WR);
    w_access   = bus.mem_req | w_host_gnt;
    w_addr     = bus.mem_req ? bus.mem_addr  : bus.host_addr;
    w_wdata    = bus.mem_req ? bus.mem_wdata : bus.host_wdata;
    w_in_range = 32'(w_addr) < DEPTH;
    w_idx      = w_addr[IW-1:0];
    w_rd_word  = w_in_range ? r_mem[w_idx] : '0;
  end

  // Store is deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_in_range & (w_bus_wr | w_host_wr)) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  mem_resp_dly #(
    .LAT (RD_LAT),
    .DW  (MEM_DW)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_bus_rd),
    .i_data (w_rd_word),
    .o_vld  (w_dly_vld),
    .o_data (w_dly_data)
  );

  // Host read returns one cycle after grant; a new grant may chain directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_host_rdata <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      r_addr_err   <= r_addr_err | (w_access & ~w_in_range);
      r_host_rdata <= w_host_rd ? w_rd_word : '0;
      case (r_state)
        ARB_IDLE:        r_state <= w_host_rd ? ARB_HOST_RD_RET : ARB_IDLE;
        ARB_HOST_RD_RET: r_state <= w_host_rd ? ARB_HOST_RD_RET : ARB_IDLE;
        default:         r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_rdata_vld = w_dly_vld;
  assign bus.mem_rdata     = w_dly_data;
  assign bus.host_gnt      = w_host_gnt;
  assign bus.host_rvld     = (r_state == ARB_HOST_RD_RET);
  assign bus.host_rdata    = r_host_rdata;
  assign bus.addr_err      = r_addr_err;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: a queue-based reference model tracks every expected
// return and a negedge monitor compares it against the outputs each cycle.
module tb_mem_resp;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned IW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_resp_if #(.AW(AW), .DW(DW)) bus ();

  mem_resp #(
    .MEM_AW (AW),
    .MEM_DW (DW),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            edge_n = 0;
  bit            exp_gnt;
  bit            exp_host_rvld;
  logic [DW-1:0] exp_host_rdata;
  bit            exp_err;
  bit            chk_en = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic bit in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return in_range(a) ? m_mem[a[IW-1:0]] : '0;
  endfunction

  // Reference model: one access per edge, bus first, reads due RD_LAT edges later.
  always @(posedge clk) begin
    edge_n++;
    exp_gnt        = bus.host_req & ~bus.mem_req;
    exp_host_rvld  = 1'b0;
    exp_host_rdata = '0;
    if (!rst_n) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else if (bus.mem_req) begin
      if (!in_range(bus.mem_addr)) exp_err = 1'b1;
      if (bus.mem_write) begin
        if (in_range(bus.mem_addr)) m_mem[bus.mem_addr[IW-1:0]] = bus.mem_wdata;
      end else begin
        exp_q.push_back('{edge_n + int'(RD_LAT), model_rd(bus.mem_addr)});
      end
    end else if (bus.host_req) begin
      if (!in_range(bus.host_addr)) exp_err = 1'b1;
      if (bus.host_write) begin
        if (in_range(bus.host_addr)) m_mem[bus.host_addr[IW-1:0]] = bus.host_wdata;
      end else begin
        exp_host_rvld  = 1'b1;
        exp_host_rdata = model_rd(bus.host_addr);
      end
    end
  end

  // Outputs seen after edge k are what the initiator samples at edge k+1.
  always @(negedge clk) begin
    if (chk_en) begin
      bit            ev;
      logic [DW-1:0] ed;
      ev = (exp_q.size() > 0) && (exp_q[0].due == edge_n + 1);
      ed = ev ? exp_q[0].data : '0;
      if (ev) void'(exp_q.pop_front());
      n_checks++;
      if (bus.mem_rdata_vld !== ev) begin
        n_fail++;
        $display("FAIL mon_rdata_vld edge %0d got %b exp %b", edge_n, bus.mem_rdata_vld, ev);
      end
      n_checks++;
      if (bus.mem_rdata !== ed) begin
        n_fail++;
        $display("FAIL mon_rdata edge %0d got %h exp %h", edge_n, bus.mem_rdata, ed);
      end
      n_checks++;
      if (bus.host_gnt !== exp_gnt) begin
        n_fail++;
        $display("FAIL mon_host_gnt edge %0d got %b exp %b", edge_n, bus.host_gnt, exp_gnt);
      end
      n_checks++;
      if (bus.host_rvld !== exp_host_rvld) begin
        n_fail++;
        $display("FAIL mon_host_rvld edge %0d got %b exp %b", edge_n, bus.host_rvld, exp_host_rvld);
      end
      n_checks++;
      if (bus.host_rdata !== exp_host_rdata) begin
        n_fail++;
        $display("FAIL mon_host_rdata edge %0d got %h exp %h", edge_n, bus.host_rdata, exp_host_rdata);
      end
      n_checks++;
      if (bus.addr_err !== exp_err) begin
        n_fail++;
        $display("FAIL mon_addr_err edge %0d got %b exp %b", edge_n, bus.addr_err, exp_err);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_drv(input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_req   = req;
    bus.mem_write = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
  endtask

  task automatic host_idle();
    bus.host_req   = 1'b0;
    bus.host_write = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  task automatic host_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd);
    bit got;
    got            = 1'b0;
    bus.host_req   = 1'b1;
    bus.host_write = wr;
    bus.host_addr  = a;
    bus.host_wdata = d;
    for (int i = 0; i < 16 && !got; i++) begin
      step();
      got = exp_gnt;
    end
    rd = bus.host_rdata;
    host_idle();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL host_op_grant addr %h got no grant exp grant", a);
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0) return AW'(DEPTH + $urandom_range(0, 200));
    if (r == 1) return AW'(DEPTH - 1 - $urandom_range(0, 7));
    if (r == 2) return '1;
    return AW'($urandom_range(0, 63));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus_drv(0, 0, '0, '0);
    host_idle();
    @(negedge clk);
    #1;
    step();
    n_checks++;
    if (bus.mem_rdata_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", bus.mem_rdata_vld); end
    n_checks++;
    if (bus.mem_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.mem_rdata); end
    n_checks++;
    if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b exp 0", bus.host_gnt); end
    n_checks++;
    if (bus.host_rvld !== 1'b0) begin n_fail++; $display("FAIL reset_hrvld got %b exp 0", bus.host_rvld); end
    n_checks++;
    if (bus.host_rdata !== '0) begin n_fail++; $display("FAIL reset_hrdata got %h exp 0", bus.host_rdata); end
    n_checks++;
    if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.addr_err); end
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step();
  endtask

  task automatic test_preload();
    logic [DW-1:0] rd;
    host_op(1'b1, 16'd0, 32'h11, rd);
    host_op(1'b1, 16'd1, 32'h22, rd);
    host_op(1'b1, 16'd2, 32'h33, rd);
    for (int a = 3; a < 64; a++) host_op(1'b1, AW'(a), $urandom, rd);
    for (int a = DEPTH - 8; a < DEPTH; a++) host_op(1'b1, AW'(a), $urandom, rd);
  endtask

  task automatic test_seq_read();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 32'h11;
    exp_d[1] = 32'h22;
    exp_d[2] = 32'h33;
    for (int i = 0; i < 3 + int'(RD_LAT); i++) begin
      bus_drv(i < 3, 1'b0, AW'(i), '0);
      step();
      if (i >= int'(RD_LAT) - 1 && i < int'(RD_LAT) + 2) begin
        n_checks++;
        if (bus.mem_rdata_vld !== 1'b1 || bus.mem_rdata !== exp_d[i - int'(RD_LAT) + 1]) begin
          n_fail++;
          $display("FAIL seq_read idx %0d got vld %b data %h exp vld 1 data %h", i - int'(RD_LAT) + 1,
                   bus.mem_rdata_vld, bus.mem_rdata, exp_d[i - int'(RD_LAT) + 1]);
        end
      end
    end
    n_checks++;
    if (bus.mem_rdata_vld !== 1'b0) begin n_fail++; $display("FAIL seq_read_tail got vld %b exp 0", bus.mem_rdata_vld); end
  endtask

  task automatic test_raw();
    bus_drv(1'b1, 1'b1, 16'd5, 32'hDEAD);
    step();
    bus_drv(1'b1, 1'b0, 16'd5, '0);
    step();
    bus_drv(1'b0, 1'b0, '0, '0);
    repeat (RD_LAT - 1) step();
    n_checks++;
    if (bus.mem_rdata_vld !== 1'b1 || bus.mem_rdata !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL raw got vld %b data %h exp vld 1 data 0000dead", bus.mem_rdata_vld, bus.mem_rdata);
    end
    step();
  endtask

  task automatic test_oob();
    bus_drv(1'b1, 1'b0, AW'(DEPTH), '0);
    step();
    bus_drv(1'b0, 1'b0, '0, '0);
    repeat (RD_LAT - 1) step();
    n_checks++;
    if (bus.mem_rdata_vld !== 1'b1 || bus.mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL oob_read got vld %b data %h exp vld 1 data 0", bus.mem_rdata_vld, bus.mem_rdata);
    end
    n_checks++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oob_err got %b exp 1", bus.addr_err); end
    bus_drv(1'b1, 1'b1, AW'(DEPTH), 32'h5);
    step();
    bus_drv(1'b1, 1'b0, 16'd0, '0);
    step();
    bus_drv(1'b0, 1'b0, '0, '0);
    repeat (RD_LAT - 1) step();
    n_checks++;
    if (bus.mem_rdata !== 32'h11) begin n_fail++; $display("FAIL oob_write_dropped got %h exp 00000011", bus.mem_rdata); end
    n_checks++;
    if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oob_err_sticky got %b exp 1", bus.addr_err); end
    step();
  endtask

  task automatic test_host_starve();
    bus.host_req   = 1'b1;
    bus.host_write = 1'b0;
    bus.host_addr  = 16'd2;
    bus.host_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus_drv(1'b1, 1'b0, 16'd0, '0);
      #1;
      n_checks++;
      if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL starve_gnt cyc %0d got %b exp 0", i, bus.host_gnt); end
      step();
    end
    bus_drv(1'b0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (bus.host_gnt !== 1'b1) begin n_fail++; $display("FAIL starve_grant got %b exp 1", bus.host_gnt); end
    step();
    host_idle();
    n_checks++;
    if (bus.host_rvld !== 1'b1 || bus.host_rdata !== 32'h33) begin
      n_fail++;
      $display("FAIL starve_rdata got rvld %b data %h exp rvld 1 data 00000033", bus.host_rvld, bus.host_rdata);
    end
    step();
    n_checks++;
    if (bus.host_rvld !== 1'b0) begin n_fail++; $display("FAIL starve_rvld_drop got %b exp 0", bus.host_rvld); end
    repeat (RD_LAT) step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 64 + int'(RD_LAT); i++) begin
      bus_drv(i < 64, 1'b0, AW'($urandom_range(0, 63)), '0);
      step();
      if (bus.mem_rdata_vld === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 64) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 64", pulses); end
  endtask

  task automatic test_random();
    bit hp;
    hp = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!hp && $urandom_range(0, 3) == 0) begin
        hp             = 1'b1;
        bus.host_req   = 1'b1;
        bus.host_write = 1'($urandom_range(0, 1));
        bus.host_addr  = pick_addr();
        bus.host_wdata = $urandom;
      end
      bus_drv($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, pick_addr(), $urandom);
      step();
      if (hp && exp_gnt) begin
        hp = 1'b0;
        host_idle();
      end
    end
    bus_drv(1'b0, 1'b0, '0, '0);
    host_idle();
    repeat (RD_LAT + 1) step();
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] rd;
    for (int i = 0; i < 3; i++) begin
      bus_drv(1'b1, 1'b0, AW'(i), '0);
      step();
    end
    bus_drv(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_err        = 1'b0;
    exp_host_rvld  = 1'b0;
    exp_host_rdata = '0;
    #1;
    n_checks++;
    if (bus.mem_rdata_vld !== 1'b0) begin n_fail++; $display("FAIL rst_fly_vld got %b exp 0", bus.mem_rdata_vld); end
    n_checks++;
    if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_fly_err got %b exp 0", bus.addr_err); end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.mem_rdata_vld !== 1'b0) begin n_fail++; $display("FAIL rst_fly_post cyc %0d got %b exp 0", i, bus.mem_rdata_vld); end
    end
    for (int a = 0; a < 3; a++) begin
      logic [DW-1:0] ev;
      ev = m_mem[a];
      host_op(1'b0, AW'(a), '0, rd);
      n_checks++;
      if (rd !== ev) begin n_fail++; $display("FAIL rst_fly_store addr %0d got %h exp %h", a, rd, ev); end
    end
    step();
  endtask

  task automatic test_matmul();
    logic [DW-1:0] ab [8];
    logic [DW-1:0] got [8];
    logic [DW-1:0] c [4];
    logic [DW-1:0] exp_c [4];
    logic [DW-1:0] rd;
    int k;
    ab[0] = 1; ab[1] = 2; ab[2] = 3; ab[3] = 4;
    ab[4] = 5; ab[5] = 6; ab[6] = 7; ab[7] = 8;
    exp_c[0] = 19; exp_c[1] = 22; exp_c[2] = 43; exp_c[3] = 50;
    for (int i = 0; i < 8; i++) begin
      bus_drv(1'b1, 1'b1, AW'(16'h100 + i), ab[i]);
      step();
    end
    k = 0;
    for (int i = 0; i < 8 + int'(RD_LAT) + 4; i++) begin
      bus_drv(i < 8, 1'b0, AW'(16'h100 + i), '0);
      step();
      if (bus.mem_rdata_vld === 1'b1 && k < 8) begin
        got[k] = bus.mem_rdata;
        k++;
      end
    end
    n_checks++;
    if (k != 8) begin n_fail++; $display("FAIL mm_returns got %0d exp 8", k); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        c[i*2+j] = got[i*2] * got[4+j] + got[i*2+1] * got[4+2+j];
    for (int i = 0; i < 4; i++) begin
      bus_drv(1'b1, 1'b1, AW'(16'h108 + i), c[i]);
      step();
    end
    bus_drv(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      host_op(1'b0, AW'(16'h108 + i), '0, rd);
      n_checks++;
      if (rd !== exp_c[i]) begin n_fail++; $display("FAIL mm_c%0d got %0d exp %0d", i, rd, exp_c[i]); end
    end
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time expired got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_seq_read();
    test_raw();
    test_oob();
    test_host_starve();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    test_matmul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
